// File: rtl/da2_arbiter.sv
// Round-robin arbiter that lets four requesters share the dual DA2 channel shadows.
// Define DA2_ARB_TIMEOUT_EN to add the START/BUSY watchdog and the err port.
//
// state | meaning
// IDLE  | waiting for any req, round-robin winner captured on exit
// LOAD  | winner's chmode/value copied into the selected channel shadow
// START | update raised, waiting for the serializer SYNC pulse
// BUSY  | frame shifting, waiting for SCLK_en to fall after it was seen high
// DONE  | one-cycle ack to the winner, pointer advanced
module da2_arbiter #(
  parameter int          TIMEOUT    = 1023,
  parameter logic [11:0] INIT_VALUE = 12'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  req_ch,
  input  logic [7:0]  req_chmode,
  input  logic [47:0] req_value,
  output logic [3:0]  ack,
  output logic        busy,
  output logic        update,
  output logic [1:0]  chmode0,
  output logic [1:0]  chmode1,
  output logic [11:0] value0,
  output logic [11:0] value1,
  input  logic        SYNC,
  input  logic        SCLK_en
`ifdef DA2_ARB_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  winner;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        found;
  logic        sclk_seen;
  logic        timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("da2_arbiter: TIMEOUT must be at least 1");
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_idx = ptr;
    cand      = ptr;
    found     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

`ifdef DA2_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  logic [WD_W-1:0] wdog;
  logic            timed_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog      <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == LOAD)
        wdog <= '0;
      else if (state == START || state == BUSY)
        wdog <= wdog + 1'b1;
      timed_out <= timeout_hit;
    end
  end

  assign timeout_hit = (state == START || state == BUSY) && (wdog == WD_W'(TIMEOUT));
  assign err         = (state == DONE) && timed_out;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = 4'b0000;
    busy      = (state != IDLE);
    update    = 1'b0;
    case (state)
      IDLE:  if (|req) state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: begin
        update = 1'b1;
        if (SYNC) state_nxt = BUSY;
      end
      BUSY:  if (sclk_seen && !SCLK_en) state_nxt = DONE;
      DONE: begin
        ack[winner] = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= 2'd3;
      winner    <= 2'd0;
      sclk_seen <= 1'b0;
      chmode0   <= 2'b00;
      chmode1   <= 2'b00;
      value0    <= INIT_VALUE;
      value1    <= INIT_VALUE;
    end else begin
      if (state == IDLE && |req) winner <= grant_idx;
      if (state == DONE) ptr <= winner;
      sclk_seen <= (state == BUSY) && (sclk_seen || SCLK_en);
      // Shadows move only here so both channels stay frozen for the frame.
      if (state == LOAD) begin
        if (req_ch[winner]) begin
          chmode1 <= req_chmode[{winner, 1'b0} +: 2];
          value1  <= req_value[int'(winner) * 12 +: 12];
        end else begin
          chmode0 <= req_chmode[{winner, 1'b0} +: 2];
          value0  <= req_value[int'(winner) * 12 +: 12];
        end
      end
    end
  end

endmodule

// File: tb/tb_da2_arbiter.sv
// Scoreboard bench for da2_arbiter with a simple DA2 serializer model.
// Define DA2_ARB_TIMEOUT_EN to also exercise the watchdog abort.
module tb_da2_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_ch;
  logic [7:0]  req_chmode;
  logic [47:0] req_value;
  logic [3:0]  ack;
  logic        busy, update;
  logic [1:0]  chmode0, chmode1;
  logic [11:0] value0, value1;
  logic        SYNC, SCLK_en;
`ifdef DA2_ARB_TIMEOUT_EN
  logic        err;
`endif

  da2_arbiter #(.TIMEOUT(15), .INIT_VALUE(12'd0)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ch(req_ch), .req_chmode(req_chmode),
    .req_value(req_value), .ack(ack), .busy(busy), .update(update),
    .chmode0(chmode0), .chmode1(chmode1), .value0(value0), .value1(value1),
    .SYNC(SYNC), .SCLK_en(SCLK_en)
`ifdef DA2_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic        ch;
    logic [1:0]  mode;
    logic [11:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ack_count = 0;
  logic ser_en = 1'b1;
  logic gap_arm = 1'b0;
  logic gap_chk = 1'b0;
  int   gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic set_req(input int i, input logic ch, input logic [1:0] mode, input logic [11:0] v);
    req_ch[i]             = ch;
    req_chmode[2*i +: 2]  = mode;
    req_value[12*i +: 12] = v;
  endtask

  task automatic push(input int i, input logic ch, input logic [1:0] mode, input logic [11:0] v);
    exp_t e;
    e.idx = 2'(i); e.ch = ch; e.mode = mode; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int target, input int budget);
    int c = 0;
    while (ack_count < target && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (ack_count < target) chk("ack_wait_timeout", 32'(ack_count), 32'(target));
  endtask

  // Serializer: SYNC one cycle after update is seen, then a 4-cycle SCLK_en burst.
  initial begin
    SYNC = 1'b0; SCLK_en = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_en && update) begin
        @(negedge clk); SYNC = 1'b1;
        @(negedge clk); SYNC = 1'b0; SCLK_en = 1'b1;
        #1 chk("update_after_sync", 32'(update), 32'd0);
        repeat (4) @(negedge clk);
        SCLK_en = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack != 4'b0000) begin
      ack_count++;
      chk("ack_onehot", 32'($countones(ack)), 32'd1);
      if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ack_idx", 32'(ack), 32'(4'b0001 << e.idx));
        if (e.ch) begin
          chk("value1", 32'(value1), 32'(e.val));
          chk("chmode1", 32'(chmode1), 32'(e.mode));
        end else begin
          chk("value0", 32'(value0), 32'(e.val));
          chk("chmode0", 32'(chmode0), 32'(e.mode));
        end
      end
      if (gap_arm) begin gap_chk = 1'b1; gap = 0; end
    end
    if (gap_chk) begin
      if (!busy) gap++;
      else if (gap != 0) begin
        chk("busy_gap", 32'(gap), 32'd1);
        gap = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    int c, tgt;
    rst = 1'b0; req = '0; req_ch = '0; req_chmode = '0; req_value = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_shadows", {4'd0, chmode0, chmode1, value0, value1}, 32'd0);
`ifdef DA2_ARB_TIMEOUT_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    do_reset();

    // Single write to channel 1
    set_req(0, 1'b1, 2'b10, 12'hABC);
    push(0, 1'b1, 2'b10, 12'hABC);
    #1 req = 4'b0001;
    wait_ack(1, 60);
    req = 4'b0000;
    repeat (10) @(negedge clk);
    #1;
    chk("t1_value1", 32'(value1), 32'hABC);
    chk("t1_value0", 32'(value0), 32'h000);
    chk("t1_ack_once", 32'(ack_count), 32'd1);

    // All four held: round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, i[0], 2'(i), 12'h100 + 12'(i));
    for (int k = 0; k < 5; k++) push(k % 4, k[0], 2'(k % 4), 12'h100 + 12'(k % 4));
    gap_arm = 1'b1;
    tgt = ack_count + 5;
    #1 req = 4'b1111;
    wait_ack(tgt, 300);
    gap_arm = 1'b0; gap_chk = 1'b0;
    req = 4'b0000;
    repeat (5) @(negedge clk);

    // Requester 2 drops req right after LOAD
    do_reset();
    set_req(2, 1'b0, 2'b01, 12'h2A2);
    push(2, 1'b0, 2'b01, 12'h2A2);
    tgt = ack_count + 1;
    #1 req = 4'b0100;
    c = 0;
    while (!busy && c < 20) begin @(negedge clk); #1; c++; end
    chk("t3_reached_load", 32'(busy), 32'd1);
    @(negedge clk); #1 req = 4'b0000;
    wait_ack(tgt, 60);
    repeat (10) @(negedge clk);
    chk("t3_ack_once", 32'(ack_count), 32'(tgt));

    // Reset during BUSY aborts the frame; requester 0 wins next
    do_reset();
    set_req(1, 1'b1, 2'b11, 12'h5A5);
    #1 req = 4'b0010;
    c = 0;
    while (!SCLK_en && c < 30) begin @(negedge clk); #1; c++; end
    chk("t4_in_busy", 32'(SCLK_en & busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_ack", 32'(ack), 32'd0);
    chk("t4_rst_update", 32'(update), 32'd0);
    chk("t4_rst_shadows", {4'd0, chmode0, chmode1, value0, value1}, 32'd0);
    tgt = ack_count;
    repeat (8) @(negedge clk);
    chk("t4_no_ack", 32'(ack_count), 32'(tgt));
    set_req(0, 1'b0, 2'b01, 12'h0F0);
    push(0, 1'b0, 2'b01, 12'h0F0);
    req = 4'b0011;
    rst = 1'b1;
    wait_ack(tgt + 1, 60);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Two requesters, two channels; channel 0 held through the second frame
    set_req(1, 1'b0, 2'b00, 12'h123);
    push(1, 1'b0, 2'b00, 12'h123);
    tgt = ack_count + 1;
    #1 req = 4'b0010;
    wait_ack(tgt, 60);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    set_req(3, 1'b1, 2'b10, 12'h456);
    push(3, 1'b1, 2'b10, 12'h456);
    #1 req = 4'b1000;
    c = 0;
    while (!SCLK_en && c < 30) begin @(negedge clk); #1; c++; end
    chk("t5_mid_value0", 32'(value0), 32'h123);
    chk("t5_mid_value1", 32'(value1), 32'h456);
    wait_ack(tgt + 1, 60);
    chk("t5_ack_value0", 32'(value0), 32'h123);
    req = 4'b0000;
    repeat (3) @(negedge clk);

`ifdef DA2_ARB_TIMEOUT_EN
    // Watchdog abort with a silent serializer
    ser_en = 1'b0;
    do_reset();
    set_req(0, 1'b0, 2'b11, 12'h777);
    push(0, 1'b0, 2'b11, 12'h777);
    #1 req = 4'b0001;
    c = 0;
    while (!update && c < 20) begin @(negedge clk); #1; c++; end
    c = 0;
    while (ack == 4'b0000 && c < 40) begin @(negedge clk); #1; c++; end
    chk("to_latency", 32'(c), 32'd16);
    chk("to_err_with_ack", {31'd0, err}, 32'd1);
    req = 4'b0000;
    @(negedge clk); #1;
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_err_pulse", 32'(err), 32'd0);
    ser_en = 1'b1;
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
